// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and constants for the byte-serialising data
//               memory arbiter (FSM states, port indices, byte-lane helper).
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    // Word transaction phases: wait for a request, issue four byte accesses,
    // collect the final read byte, then pulse completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        TAIL = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int PORT_CPU       = 0;
    localparam int PORT_DBG       = 1;

    // Byte counter value of the final byte issue of a word.
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    // Extract byte lane 'lane' (lane 3 = bits 31:24) from a word.
    function automatic logic [7:0] word_lane(input logic [31:0] word,
                                             input logic [1:0]  lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-requester round-robin arbiter. Grant is combinational
//               from req; the priority pointer moves away from the winner
//               whenever 'advance' is asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // 0: port 0 wins a tie, 1: port 1 wins a tie.
    logic r_prio;

    // One-hot grant: a lone requester always wins, a tie goes to the pointer.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant[PORT_CPU] = 1'b1;
            2'b10:   grant[PORT_DBG] = 1'b1;
            2'b11:   grant = r_prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Pointer favours whichever port did not just win.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (advance) begin
            r_prio <= grant[PORT_CPU];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares a byte-wide synchronous data memory between the CPU
//               data port (0) and the loader/debug port (1). Each 32-bit
//               word access is serialised into four big-endian byte accesses
//               (byte at addr = bits 31:24), one word in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_we,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [31:0]       req_wdata0,
    input  logic [31:0]       req_wdata1,
    output logic [1:0]        req_ready,
    output logic [1:0]        rsp_done,
    output logic [31:0]       rsp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_owner;
    logic [31:0]       r_rbuf;
    logic [31:0]       r_rdata;

    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    logic              w_accept;
    logic [1:0]        w_rd_lane;

    // Requests are only offered to the arbiter while idle and out of reset.
    assign w_req    = (r_state == IDLE && rst_n) ? req_valid : 2'b00;
    assign w_accept = |w_grant;

    // The byte returned now was issued one count earlier.
    assign w_rd_lane = 2'd3 - (r_cnt - 2'd1);

    assign rsp_rdata = r_rdata;

    rr_arbiter2 u_rr_arbiter2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (w_req),
        .advance (w_accept),
        .grant   (w_grant)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and all handshake / memory strobes. Outputs are forced low
    // while reset is asserted so an aborted word issues no further bytes.
    always_comb begin
        w_state_next = r_state;
        req_ready    = 2'b00;
        rsp_done     = 2'b00;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = 8'h00;
        case (r_state)
            IDLE: begin
                req_ready = w_grant;
                if (w_accept) begin
                    w_state_next = XFER;
                end
            end
            XFER: begin
                mem_en    = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_addr + ADDR_W'(r_cnt);
                mem_wdata = word_lane(r_wdata, 2'd3 - r_cnt);
                if (r_cnt == LAST_BYTE) begin
                    w_state_next = TAIL;
                end
            end
            TAIL: begin
                w_state_next = RESP;
            end
            RESP: begin
                rsp_done     = r_owner ? 2'b10 : 2'b01;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (!rst_n) begin
            w_state_next = IDLE;
            req_ready    = 2'b00;
            rsp_done     = 2'b00;
            mem_en       = 1'b0;
            mem_we       = 1'b0;
            mem_addr     = '0;
            mem_wdata    = 8'h00;
        end
    end

    // Request capture, byte counter and read-data assembly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= 2'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_owner <= 1'b0;
            r_rbuf  <= 32'h0;
            r_rdata <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= 2'd0;
                        r_owner <= w_grant[PORT_DBG];
                        r_we    <= req_we[w_grant[PORT_DBG]];
                        r_addr  <= w_grant[PORT_DBG] ? req_addr1  : req_addr0;
                        r_wdata <= w_grant[PORT_DBG] ? req_wdata1 : req_wdata0;
                    end
                end
                XFER: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (!r_we && r_cnt != 2'd0) begin
                        r_rbuf[{w_rd_lane, 3'b000} +: 8] <= mem_rdata;
                    end
                end
                TAIL: begin
                    // Publish the finished word so it is valid with done.
                    if (!r_we) begin
                        r_rdata <= {r_rbuf[31:8], mem_rdata};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter: a transaction-level
//               model predicts every output each cycle, plus literal checks
//               on memory contents, read data and grant order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int ADDR_W = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_we = 2'b00;
    logic [4:0]  req_addr0 = 5'd0;
    logic [4:0]  req_addr1 = 5'd0;
    logic [31:0] req_wdata0 = 32'h0;
    logic [31:0] req_wdata1 = 32'h0;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_done;
    logic [31:0] rsp_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .req_ready  (req_ready),
        .rsp_done   (rsp_done),
        .rsp_rdata  (rsp_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Synchronous byte memory behind the arbiter.
    logic [7:0] mem [0:31] = '{default: 8'h00};
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model -----------------
    // m_phase: 0 idle, 1..4 byte k-1 on the bus, 5 gap, 6 completion.
    logic [7:0]  mref [0:31] = '{default: 8'h00};
    int          m_phase = 0;
    logic        m_ptr = 1'b0;
    logic        m_owner = 1'b0;
    logic        m_we = 1'b0;
    logic [4:0]  m_addr = 5'd0;
    logic [31:0] m_wdata = 32'h0;
    logic [31:0] m_word = 32'h0;
    logic [31:0] m_rdata = 32'h0;
    logic [1:0]  e_ready, e_done;
    logic        e_en, e_we;
    logic [4:0]  e_addr, tmp_a;
    logic [7:0]  e_wd;
    int          g;

    // Compare every output each cycle, then advance the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", {30'b0, req_ready}, 32'h0);
            chk("rst_done", {30'b0, rsp_done}, 32'h0);
            chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
            chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
            chk("rst_mem_addr", {27'b0, mem_addr}, 32'h0);
            chk("rst_mem_wdata", {24'b0, mem_wdata}, 32'h0);
            m_phase = 0;
            m_ptr   = 1'b0;
            m_rdata = 32'h0;
        end else begin
            e_ready = 2'b00; e_done = 2'b00; e_en = 1'b0; e_we = 1'b0;
            e_addr = 5'd0; e_wd = 8'h00; g = -1;
            if (m_phase == 0) begin
                if (req_valid == 2'b11)  g = m_ptr ? 1 : 0;
                else if (req_valid[0])   g = 0;
                else if (req_valid[1])   g = 1;
                if (g >= 0) e_ready[g] = 1'b1;
            end else if (m_phase <= 4) begin
                e_en   = 1'b1;
                e_we   = m_we;
                e_addr = m_addr + 5'(m_phase - 1);
                e_wd   = m_wdata[8*(4-m_phase) +: 8];
            end else if (m_phase == 6) begin
                e_done[m_owner] = 1'b1;
            end
            chk("req_ready", {30'b0, req_ready}, {30'b0, e_ready});
            chk("rsp_done", {30'b0, rsp_done}, {30'b0, e_done});
            chk("mem_en", {31'b0, mem_en}, {31'b0, e_en});
            chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
            if (e_en) begin
                chk("mem_addr", {27'b0, mem_addr}, {27'b0, e_addr});
                chk("mem_wdata", {24'b0, mem_wdata}, {24'b0, e_wd});
            end
            chk("rsp_rdata", rsp_rdata, m_rdata);

            if (m_phase >= 1 && m_phase <= 4 && m_we) mref[e_addr] = e_wd;
            if (m_phase == 5 && !m_we) m_rdata = m_word;
            if (g >= 0) begin
                m_owner = g[0];
                m_we    = req_we[g];
                m_addr  = (g == 1) ? req_addr1 : req_addr0;
                m_wdata = (g == 1) ? req_wdata1 : req_wdata0;
                m_word  = 32'h0;
                for (int b = 0; b < 4; b++) begin
                    tmp_a  = m_addr + 5'(b);
                    m_word = {m_word[23:0], mref[tmp_a]};
                end
                m_ptr   = (g == 0);
                m_phase = 1;
            end else if (m_phase == 6) begin
                m_phase = 0;
            end else if (m_phase != 0) begin
                m_phase++;
            end
        end
    end

    // ---------------- stimulus -----------------
    task automatic drive(input int p, input logic we, input logic [4:0] a, input logic [31:0] d);
        req_we[p] = we;
        if (p == 0) begin req_addr0 = a; req_wdata0 = d; end
        else        begin req_addr1 = a; req_wdata1 = d; end
        req_valid[p] = 1'b1;
    endtask

    task automatic wait_ready(input int p, output logic got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[p]) begin got = 1'b1; break; end
        end
        chk("ready_seen", {31'b0, got}, 32'h1);
    endtask

    task automatic do_req(input int p, input logic we, input logic [4:0] a,
                          input logic [31:0] d, output logic [31:0] rd);
        logic got;
        rd = 32'hx;
        drive(p, we, a, d);
        wait_ready(p, got);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_done[p]) begin got = 1'b1; rd = rsp_rdata; break; end
        end
        chk("done_seen", {31'b0, got}, 32'h1);
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic [1:0]  gseq [0:3];
    logic        got, seen0, seen1;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Both ports reading continuously from reset: grants alternate 0,1,0,1.
        req_we = 2'b00; req_addr0 = 5'd0; req_addr1 = 5'd4; req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            gseq[k] = 2'b00;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (req_ready != 2'b00) begin gseq[k] = req_ready; break; end
            end
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        repeat (8) @(posedge clk);
        #1;
        chk("grant_seq0", {30'b0, gseq[0]}, 32'h1);
        chk("grant_seq1", {30'b0, gseq[1]}, 32'h2);
        chk("grant_seq2", {30'b0, gseq[2]}, 32'h1);
        chk("grant_seq3", {30'b0, gseq[3]}, 32'h2);

        // Port 0 write, then port 1 read-back.
        do_req(0, 1'b1, 5'd8, 32'hDEADBEEF, rd);
        chk("wr_rdata_held", rd, 32'h0);
        chk("wr_bytes_8_11", {mem[8], mem[9], mem[10], mem[11]}, 32'hDEADBEEF);
        do_req(1, 1'b0, 5'd8, 32'h0, rd);
        chk("rd_addr8", rd, 32'hDEADBEEF);

        // Address wrap 30,31,0,1.
        do_req(0, 1'b1, 5'd30, 32'h11223344, rd);
        chk("wrap_bytes", {mem[30], mem[31], mem[0], mem[1]}, 32'h11223344);
        do_req(1, 1'b0, 5'd30, 32'h0, rd);
        chk("wrap_read", rd, 32'h11223344);

        // Port 1 pulses valid for one cycle during port 0's transfer.
        drive(0, 1'b1, 5'd16, 32'h01020304);
        wait_ready(0, got);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        @(posedge clk); #1 drive(1, 1'b0, 5'd16, 32'h0);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        seen0 = 1'b0; seen1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_done[0]) seen0 = 1'b1;
            if (rsp_done[1] || req_ready[1]) seen1 = 1'b1;
        end
        chk("drop_p0_done", {31'b0, seen0}, 32'h1);
        chk("drop_p1_quiet", {31'b0, seen1}, 32'h0);
        @(posedge clk); #1;

        // Reset two cycles into a write: only the first byte lands.
        drive(0, 1'b1, 5'd4, 32'hA5A5A5A5);
        wait_ready(0, got);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_byte4", {24'b0, mem[4]}, 32'hA5);
        chk("abort_byte5", {24'b0, mem[5]}, 32'h00);
        chk("abort_rdata", rsp_rdata, 32'h0);

        // After reset a tie goes to port 0 again.
        req_we = 2'b00; req_addr0 = 5'd4; req_addr1 = 5'd16; req_valid = 2'b11;
        @(negedge clk);
        chk("post_rst_grant", {30'b0, req_ready}, 32'h1);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        wait_ready(1, got);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_done[1]) begin got = 1'b1; rd = rsp_rdata; break; end
        end
        chk("post_rst_done", {31'b0, got}, 32'h1);
        chk("post_rst_read", rd, 32'h01020304);
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 32; i++) begin
            chk("mem_final", {24'b0, mem[i]}, {24'b0, mref[i]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the byte-wide data memory between two word requesters: port 0 is the CPU data port and port 1 is the loader/debug port.
- Serializes each 32-bit access into four big-endian byte accesses. The byte at addr holds bits 31:24.
- Round-robin arbitration. One word transaction in flight at a time.
- Sits between the processor datapath and the datmem array, replacing direct multi-byte indexing.

Parameters:
- ADDR_W, 5, byte address width. Memory depth is 2^ADDR_W bytes (32).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  2  per-port request valid; bit i = port i
- req_we  in  2  per-port write enable (1 = write word)
- req_addr0 / req_addr1  in  ADDR_W  per-port byte address of word MSB
- req_wdata0 / req_wdata1  in  32  per-port write word
- req_ready  out  2  one-hot; high for exactly the cycle port i's request is captured
- rsp_done  out  2  one-hot single-cycle completion pulse to the owning port
- rsp_rdata  out  32  read word; valid when rsp_done != 0 and the captured op was a read; held until the next done
- mem_en  out  1  byte access strobe
- mem_we  out  1  byte write enable
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  byte write data
- mem_rdata  in  8  byte read data; sync memory, valid the cycle after mem_en with mem_we=0

Behaviour:
- States: IDLE, XFER (byte counter cnt 0..3), TAIL, RESP.
- IDLE, arbitration:
  - Any req_valid bit set → grant by round-robin.
  - If both bits are set, the port not granted last wins. The pointer resets to favour port 0.
  - req_ready[g] is high this cycle (combinational, forced 0 while rst_n=0). Latch we, addr, wdata, owner g.
  - Next state XFER with cnt=0. Flip pointer to favour the other port.
- XFER:
  - mem_en=1, mem_we=captured we, mem_addr = addr+cnt mod 2^ADDR_W (wraps 31→0).
  - mem_wdata = word byte (3-cnt): cnt 0 → bits 31:24.
  - Reads capture mem_rdata of the previous issue into byte lane (3-(cnt-1)).
  - cnt=3 → TAIL.
- TAIL: mem_en=0. Reads capture the last byte into bits 7:0. Next state RESP.
- RESP: rsp_done[owner]=1 for one cycle. rsp_rdata is updated (reads only; writes leave it unchanged). Next state IDLE.
- Latency: accept at cycle T, bytes issued T+1..T+4, done at T+6. The next accept is earliest at T+7.
- Requesters hold valid/we/addr/wdata stable until ready. Dropping valid before ready is legal and causes no capture. A port requesting while another transaction is in flight waits, with ready=0.
- Simultaneous: both valid in IDLE → exactly one ready bit. The loser stays pending and wins the next IDLE arbitration.
- Reset values (rst_n=0 at any edge):
  - state IDLE, pointer → port 0
  - req_ready=0, rsp_done=0, rsp_rdata=0
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0
- Reset mid-XFER aborts with no done pulse. Bytes already written stay written; no rollback.
- mem_we is never high while mem_en is low.

Decomposition:
- Package dmem_arb_pkg:
  - state enum (IDLE, XFER, TAIL, RESP)
  - BYTES_PER_WORD=4
  - PORT_CPU=0, PORT_DBG=1
- One sub-module, rr_arbiter2:
  - inputs: req[1:0], advance, clk, rst_n
  - output: one-hot grant
  - holds the priority pointer; advance=1 on accept

Test Plan:
- Port 0 writes 0xDEADBEEF at addr 8 → mem writes DE@8, AD@9, BE@10, EF@11 on T+1..T+4; rsp_done=01 at T+6; rsp_rdata unchanged.
- Port 1 reads addr 8 after the previous write → rsp_done=10 at T+6, rsp_rdata=0xDEADBEEF.
- Port 0 writes 0x11223344 at addr 30 → bytes land at 30, 31, 0, 1 (wrap); a read at 30 returns 0x11223344.
- Both ports valid in IDLE from reset → port 0 granted first and port 1 second. With both held continuously, grants alternate 0,1,0,1.
- rst_n low at T+2 of a write of 0xA5A5A5A5 at addr 4 → only addr 4 written (byte A5); no done pulse; outputs zero next cycle; the next request is accepted normally with port-0 priority.
- Port 1 raises valid for one cycle while port 0's transfer is in XFER, then drops it → no ready or done for port 1; only port 0 completes.
